// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one execution-unit result per cycle (round-robin plus a
// starvation-bounded priority lane) and registers it in a single-entry broadcast stage.
module cdb_arbiter #(
    parameter int unsigned EU_N     = 8,
    parameter int unsigned DATA_W   = 96,
    parameter bit          PRIO_EN  = 1'b1,
    parameter int unsigned PRIO_EU  = 0,
    parameter int unsigned PRIO_MAX = 4,
    localparam int unsigned SRC_W   = (EU_N > 1) ? $clog2(EU_N) : 1,
    localparam int unsigned CNT_W   = $clog2(PRIO_MAX + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic [EU_N-1:0]        eu_valid_i,
    output logic [EU_N-1:0]        eu_ready_o,
    input  logic [EU_N*DATA_W-1:0] eu_data_i,
    input  logic                   rob_ready_i,
    output logic                   cdb_valid_o,
    output logic [DATA_W-1:0]      cdb_data_o,
    output logic [SRC_W-1:0]       cdb_src_o
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  prio_cnt_q, prio_cnt_d;

    logic              load_en;
    logic              others_wait;
    logic              prio_sat;
    logic              prio_win;
    logic              rr_found;
    logic              grant_en;
    logic [EU_N-1:0]   prio_mask;
    logic [EU_N-1:0]   scan_valid;
    logic [EU_N-1:0]   grant_oh;
    logic [SRC_W-1:0]  rr_idx;
    logic [SRC_W-1:0]  win_idx;
    logic [SRC_W-1:0]  rr_next;

    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input int unsigned off);
        logic [31:0] sum;
        sum = 32'(base) + off;
        if (sum >= EU_N) begin
            sum = sum - EU_N;
        end
        return SRC_W'(sum);
    endfunction

    assign load_en = ~out_valid_q | rob_ready_i;

    always_comb begin
        prio_mask          = '0;
        prio_mask[PRIO_EU] = 1'b1;
        others_wait        = |(eu_valid_i & ~prio_mask);
        prio_sat           = (prio_cnt_q == CNT_W'(PRIO_MAX));
        prio_win           = PRIO_EN && eu_valid_i[PRIO_EU] && !(prio_sat && others_wait);

        // Once the priority lane has used its budget it must yield to the round-robin scan.
        scan_valid = eu_valid_i;
        if (PRIO_EN && prio_sat) begin
            scan_valid[PRIO_EU] = 1'b0;
        end

        rr_found = 1'b0;
        rr_idx   = '0;
        for (int unsigned off = 0; off < EU_N; off++) begin
            if (!rr_found && scan_valid[wrap_add(rr_ptr_q, off)]) begin
                rr_found = 1'b1;
                rr_idx   = wrap_add(rr_ptr_q, off);
            end
        end

        win_idx = prio_win ? SRC_W'(PRIO_EU) : rr_idx;
        rr_next = (win_idx == SRC_W'(EU_N - 1)) ? '0 : win_idx + SRC_W'(1);

        grant_en = load_en && !flush_i && !rst_i && (|eu_valid_i) && (prio_win || rr_found);

        grant_oh = '0;
        if (grant_en) begin
            grant_oh[win_idx] = 1'b1;
        end
    end

    assign eu_ready_o = grant_oh;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        rr_ptr_d    = rr_ptr_q;
        prio_cnt_d  = prio_cnt_q;

        if (flush_i) begin
            out_valid_d = 1'b0;
            prio_cnt_d  = '0;
        end else if (grant_en) begin
            out_valid_d = 1'b1;
            out_data_d  = eu_data_i[32'(win_idx) * DATA_W +: DATA_W];
            out_src_d   = win_idx;
            if (prio_win) begin
                // A priority win with others waiting implies the counter is below saturation.
                prio_cnt_d = others_wait ? prio_cnt_q + CNT_W'(1) : '0;
            end else begin
                rr_ptr_d   = rr_next;
                prio_cnt_d = '0;
            end
        end else if (rob_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (!PRIO_EN) begin
            prio_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= '0;
            prio_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            rr_ptr_q    <= rr_ptr_d;
            prio_cnt_q  <= prio_cnt_d;
        end
    end

    assign cdb_valid_o = out_valid_q;
    assign cdb_data_o  = out_data_q;
    assign cdb_src_o   = out_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: expected broadcasts are queued at grant time and
// compared when they appear on the CDB; each scenario task checks grants inline.
module tb_cdb_arbiter;

    localparam int EU_N   = 8;
    localparam int DATA_W = 96;

    typedef struct packed {
        logic [2:0]        src;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic                   rob_ready_i;
    logic [EU_N-1:0]        eu_valid;
    logic [EU_N*DATA_W-1:0] eu_data;

    logic [EU_N-1:0]   ready_m, ready_r;
    logic              cvalid_m, cvalid_r;
    logic [DATA_W-1:0] cdata_m, cdata_r;
    logic [2:0]        csrc_m, csrc_r;

    logic              sel_rr;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic [2:0]        obs_src;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .EU_N(EU_N), .DATA_W(DATA_W), .PRIO_EN(1'b1), .PRIO_EU(0), .PRIO_MAX(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .eu_valid_i(eu_valid),
        .eu_ready_o(ready_m), .eu_data_i(eu_data), .rob_ready_i(rob_ready_i),
        .cdb_valid_o(cvalid_m), .cdb_data_o(cdata_m), .cdb_src_o(csrc_m)
    );

    cdb_arbiter #(
        .EU_N(EU_N), .DATA_W(DATA_W), .PRIO_EN(1'b0), .PRIO_EU(0), .PRIO_MAX(4)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .eu_valid_i(eu_valid),
        .eu_ready_o(ready_r), .eu_data_i(eu_data), .rob_ready_i(rob_ready_i),
        .cdb_valid_o(cvalid_r), .cdb_data_o(cdata_r), .cdb_src_o(csrc_r)
    );

    assign obs_valid = sel_rr ? cvalid_r : cvalid_m;
    assign obs_data  = sel_rr ? cdata_r : cdata_m;
    assign obs_src   = sel_rr ? csrc_r : csrc_m;

    // Scoreboard consumer: every accepted broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst_i && !flush_i && obs_valid && rob_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL broadcast_unexpected: src=%0d data=%h, required no broadcast",
                         obs_src, obs_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (obs_src !== mon_e.src || obs_data !== mon_e.data)
                    $display("FAIL broadcast: src=%0d data=%h, required src=%0d data=%h",
                             obs_src, obs_data, mon_e.src, mon_e.data);
                else n_pass++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] pay(input int lane, input int tag);
        return {16'hCDB0, 8'(lane), 8'(tag), 32'(tag * 17 + lane), 32'hDEAD_0000 | 32'(lane)};
    endfunction

    task automatic set_data(input int tag);
        for (int i = 0; i < EU_N; i++) eu_data[i*DATA_W +: DATA_W] = pay(i, tag);
    endtask

    task automatic push_exp(input int src, input logic [DATA_W-1:0] data);
        exp_t ent;
        ent.src  = 3'(src);
        ent.data = data;
        exp_q.push_back(ent);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        flush_i  = 1'b0;
        eu_valid = '0;
        tick();
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        rob_ready_i = 1'b1;
        eu_valid    = 8'hFF;
        set_data(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h00) $display("FAIL reset_ready: eu_ready=%b required 0", ready_m);
        else n_pass++;
        n_checks++;
        if (ready_r !== 8'h00) $display("FAIL reset_ready_rr: eu_ready=%b required 0", ready_r);
        else n_pass++;
        n_checks++;
        if (cvalid_m !== 1'b0 || csrc_m !== 3'd0 || cdata_m !== '0)
            $display("FAIL reset_out: valid=%b src=%0d data=%h required all 0",
                     cvalid_m, csrc_m, cdata_m);
        else n_pass++;
        eu_valid = '0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        int          seq[3] = '{0, 2, 7};
        int          w;
        int          exp_ptr;
        logic [7:0]  exp_rdy;
        sel_rr = 1'b1;
        do_reset();
        rob_ready_i = 1'b1;
        eu_valid    = 8'b1000_0101;
        for (int i = 0; i < EU_N; i++) eu_data[i*DATA_W +: DATA_W] = DATA_W'(i);
        exp_ptr = 0;
        for (int k = 0; k < 9; k++) begin
            w       = seq[k % 3];
            exp_rdy = 8'b1 << w;
            push_exp(w, DATA_W'(w));
            @(negedge clk);
            n_checks++;
            if (ready_r !== exp_rdy)
                $display("FAIL rr_grant[%0d]: eu_ready=%b required %b", k, ready_r, exp_rdy);
            else n_pass++;
            n_checks++;
            if (dut_rr.rr_ptr_q !== 3'(exp_ptr))
                $display("FAIL rr_ptr[%0d]: rr_ptr=%0d required %0d", k, dut_rr.rr_ptr_q, exp_ptr);
            else n_pass++;
            exp_ptr = (w + 1) % EU_N;
            tick();
        end
        eu_valid = '0;
        @(negedge clk);
        n_checks++;
        if (ready_r !== 8'h00) $display("FAIL rr_idle: eu_ready=%b required 0", ready_r);
        else n_pass++;
        n_checks++;
        if (dut_rr.prio_cnt_q !== 3'd0)
            $display("FAIL rr_prio_cnt: prio_cnt=%0d required 0", dut_rr.prio_cnt_q);
        else n_pass++;
        tick();
        sel_rr = 1'b0;
    endtask

    task automatic test_priority_bound();
        int         pseq[5] = '{0, 0, 0, 0, 3};
        int         pcnt[5] = '{0, 1, 2, 3, 4};
        int         w;
        logic [7:0] exp_rdy;
        do_reset();
        rob_ready_i = 1'b1;
        eu_valid    = 8'b0000_1001;
        for (int k = 0; k < 10; k++) begin
            set_data(k);
            w       = pseq[k % 5];
            exp_rdy = 8'b1 << w;
            push_exp(w, pay(w, k));
            @(negedge clk);
            n_checks++;
            if (ready_m !== exp_rdy)
                $display("FAIL prio_grant[%0d]: eu_ready=%b required %b", k, ready_m, exp_rdy);
            else n_pass++;
            n_checks++;
            if (dut.prio_cnt_q !== 3'(pcnt[k % 5]))
                $display("FAIL prio_cnt[%0d]: prio_cnt=%0d required %0d",
                         k, dut.prio_cnt_q, pcnt[k % 5]);
            else n_pass++;
            tick();
        end
        eu_valid = '0;
        @(negedge clk);
        n_checks++;
        if (dut.prio_cnt_q !== 3'd0)
            $display("FAIL prio_cnt_end: prio_cnt=%0d required 0", dut.prio_cnt_q);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        rob_ready_i = 1'b0;
        eu_data     = '0;
        eu_data[DATA_W-1:0] = DATA_W'(8'hA5);
        eu_valid    = 8'h01;
        push_exp(0, DATA_W'(8'hA5));
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h01) $display("FAIL bp_load: eu_ready=%b required 00000001", ready_m);
        else n_pass++;
        tick();
        eu_valid = 8'b0001_0010;
        set_data(7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (ready_m !== 8'h00)
                $display("FAIL bp_stall_ready[%0d]: eu_ready=%b required 0", k, ready_m);
            else n_pass++;
            n_checks++;
            if (cvalid_m !== 1'b1 || cdata_m !== DATA_W'(8'hA5))
                $display("FAIL bp_hold[%0d]: valid=%b data=%h required valid=1 data=a5",
                         k, cvalid_m, cdata_m);
            else n_pass++;
            tick();
        end
        rob_ready_i = 1'b1;
        push_exp(1, pay(1, 7));
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h02) $display("FAIL bp_release: eu_ready=%b required 00000010", ready_m);
        else n_pass++;
        tick();
        eu_valid = '0;
        @(negedge clk);
        n_checks++;
        if (cvalid_m !== 1'b1 || csrc_m !== 3'd1)
            $display("FAIL bp_no_bubble: valid=%b src=%0d required valid=1 src=1",
                     cvalid_m, csrc_m);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush();
        // Continues from backpressure: rr_ptr_q is 2 and the output stage is empty.
        rob_ready_i = 1'b0;
        eu_valid    = 8'h01;
        set_data(9);
        push_exp(0, pay(0, 9));
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h01) $display("FAIL flush_load: eu_ready=%b required 00000001", ready_m);
        else n_pass++;
        tick();
        flush_i     = 1'b1;
        rob_ready_i = 1'b1;
        eu_valid    = 8'b0010_0100;
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h00) $display("FAIL flush_ready: eu_ready=%b required 0", ready_m);
        else n_pass++;
        tick();
        flush_i = 1'b0;
        push_exp(2, pay(2, 9));
        @(negedge clk);
        n_checks++;
        if (cvalid_m !== 1'b0) $display("FAIL flush_valid: cdb_valid=%b required 0", cvalid_m);
        else n_pass++;
        n_checks++;
        if (dut.rr_ptr_q !== 3'd2)
            $display("FAIL flush_ptr: rr_ptr=%0d required 2", dut.rr_ptr_q);
        else n_pass++;
        n_checks++;
        if (ready_m !== 8'h04) $display("FAIL flush_resume: eu_ready=%b required 00000100", ready_m);
        else n_pass++;
        tick();
        eu_valid = '0;
        tick();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        rob_ready_i = 1'b1;
        eu_valid    = 8'b0010_1010;
        set_data(20);
        push_exp(1, pay(1, 20));
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h02) $display("FAIL mid_grant0: eu_ready=%b required 00000010", ready_m);
        else n_pass++;
        tick();
        set_data(21);
        push_exp(3, pay(3, 21));
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h08) $display("FAIL mid_grant1: eu_ready=%b required 00001000", ready_m);
        else n_pass++;
        tick();
        rst_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (ready_m !== 8'h00) $display("FAIL mid_rst_ready: eu_ready=%b required 0", ready_m);
        else n_pass++;
        tick();
        rst_i = 1'b0;
        set_data(22);
        push_exp(1, pay(1, 22));
        @(negedge clk);
        n_checks++;
        if (cvalid_m !== 1'b0 || csrc_m !== 3'd0)
            $display("FAIL mid_rst_out: valid=%b src=%0d required valid=0 src=0",
                     cvalid_m, csrc_m);
        else n_pass++;
        n_checks++;
        if (ready_m !== 8'h02)
            $display("FAIL mid_restart: eu_ready=%b required 00000010", ready_m);
        else n_pass++;
        tick();
        eu_valid = '0;
        tick();
    endtask

    task automatic test_single_requester();
        do_reset();
        rob_ready_i = 1'b1;
        eu_valid    = 8'h40;
        for (int k = 0; k < 6; k++) begin
            set_data(30 + k);
            push_exp(6, pay(6, 30 + k));
            @(negedge clk);
            n_checks++;
            if (ready_m !== 8'h40)
                $display("FAIL single_grant[%0d]: eu_ready=%b required 01000000", k, ready_m);
            else n_pass++;
            if (k > 0) begin
                n_checks++;
                if (cvalid_m !== 1'b1 || dut.rr_ptr_q !== 3'd7)
                    $display("FAIL single_stream[%0d]: valid=%b rr_ptr=%0d required 1 and 7",
                             k, cvalid_m, dut.rr_ptr_q);
                else n_pass++;
            end
            tick();
        end
        eu_valid = '0;
        tick();
    endtask

    initial begin
        sel_rr      = 1'b0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        rob_ready_i = 1'b0;
        eu_valid    = '0;
        eu_data     = '0;
        test_reset();
        test_round_robin();
        test_priority_bound();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_single_requester();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
